hazard_forward_unit: RTL
========================

Name: hazard_forward_unit

Overview:
- Parametrised successor to the pipeline hazard detector for the 5-stage MIPS core.
- Adds the following to the existing load-use stall and branch/jump bubble:
  - zero-register filtering;
  - per-operand use qualifiers;
  - a multi-cycle multiply/divide (MDU) busy interlock with its own countdown;
  - EX-stage forwarding selects;
  - a saturating stall-cycle performance counter.
- Sits beside the ID/EX control path. It drives the PC enable, IF/ID enable, IF/ID flush and the ID/EX control mux.

Parameters:
- REG_ADDR_W, 5, register address width.
- MDU_LATENCY, 32, cycles the MDU is busy after a start is issued from EX; legal range 1 to 2^MDU_CNT_W-1.
- MDU_CNT_W, 6, width of the MDU countdown.
- STALL_CNT_W, 32, width of the stall performance counter.
- ZERO_REG_PROTECT, 1, when 1 an address of 0 never produces a match (stall or forward).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_readE  in  1  EX instruction is a load.
- rt_addrE  in  REG_ADDR_W  load destination in EX.
- rs_addrD, rt_addrD  in  REG_ADDR_W  ID source addresses.
- rs_usedD, rt_usedD  in  1  ID instruction actually reads rs / rt.
- rs_addrE, rt_addrE_src  in  REG_ADDR_W  EX source addresses, used for forwarding.
- reg_writeM, reg_writeW  in  1  MEM / WB stages write the register file.
- rd_addrM, rd_addrW  in  REG_ADDR_W  MEM / WB destination addresses.
- pc_src  in  1  branch taken (resolved in ID).
- jumpD  in  1  jump in ID.
- mdu_startE  in  1  mult/div issued from EX this cycle.
- mdu_startD, hilo_readD  in  1  ID holds a mult/div, or an mfhi/mflo.
- perf_clear  in  1  synchronous clear of stall_count.
- pc_enable  out  1  1 = PC updates.
- instr_enable  out  1  1 = IF/ID register updates.
- control_mux  out  1  1 = pass ID control, 0 = insert bubble into ID/EX.
- flush_ifid  out  1  1 = IF/ID loads a NOP.
- forward_a, forward_b  out  2  EX operand select: 00 = register file, 10 = MEM result, 01 = WB result.
- mdu_busy  out  1  MDU countdown nonzero.
- mdu_done  out  1  one-cycle pulse when the countdown reaches 0.
- stall_count  out  STALL_CNT_W  count of cycles with pc_enable=0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - mdu_cnt=0, stall_count=0, mdu_done=0.
  - Combinational outputs are forced while rst_n=0: pc_enable=0, instr_enable=0, control_mux=0, flush_ifid=0, forward_a=forward_b=00.
  - Reset asserted mid-MDU operation aborts the countdown; mdu_busy=0 from the reset edge.
- match(a,b) = (a==b) && !(ZERO_REG_PROTECT && a==0).
- load_use = mem_readE && ((rs_usedD && match(rt_addrE,rs_addrD)) || (rt_usedD && match(rt_addrE,rt_addrD))).
- mdu_hold = mdu_busy && (hilo_readD || mdu_startD).
- stall = load_use || mdu_hold.
- Output priority, combinational, zero latency:
  1. stall: pc_enable=0, instr_enable=0, control_mux=0, flush_ifid=0.
  2. else pc_src||jumpD: pc_enable=1, instr_enable=1, control_mux=0, flush_ifid=1.
  3. else: all enables 1, control_mux=1, flush_ifid=0.
  - A stall coincident with a branch or jump suppresses the flush. The branch re-resolves in a later cycle.
- MDU countdown, on the clock edge:
  - mdu_startE=1: mdu_cnt <= MDU_LATENCY. A restart while busy reloads the counter and produces no mdu_done.
  - else mdu_cnt!=0: mdu_cnt <= mdu_cnt-1.
  - mdu_busy = (mdu_cnt!=0).
  - mdu_done is registered: 1 for exactly the cycle after mdu_cnt transitions 1 -> 0, otherwise 0.
  - MDU_LATENCY=1 gives busy for one cycle, then done.
- Forwarding (forward_a uses rs_addrE; forward_b uses rt_addrE_src):
  - 10 if reg_writeM && match(rd_addrM,src).
  - else 01 if reg_writeW && match(rd_addrW,src).
  - else 00.
  - MEM has priority over WB when both match.
- stall_count:
  - perf_clear=1: cleared to 0. Clear wins over increment in the same cycle.
  - else, when pc_enable=0 and rst_n=1: increment by 1, saturating at all-ones (no wrap).

Test Plan:
- Load-use stall: mem_readE=1, rt_addrE=8, rs_addrD=8, rs_usedD=1 -> pc_enable=0, instr_enable=0, control_mux=0 for that cycle; stall_count increments by 1.
- Zero-register filtering: same stimulus with rt_addrE=0, rs_addrD=0, ZERO_REG_PROTECT=1 -> no stall, all enables 1, control_mux=1. Separately, rt_usedD=0 with a matching rt -> no stall.
- MDU interlock, MDU_LATENCY=4:
  - mdu_startE pulse -> mdu_busy=1 for 4 cycles; mdu_done=1 on the 5th cycle only.
  - hilo_readD=1 throughout -> pc_enable=0 for exactly 4 cycles; stall_count=4.
- Branch and priority:
  - pc_src=1 alone -> flush_ifid=1, control_mux=0, pc_enable=1.
  - pc_src=1 together with load_use -> flush_ifid=0, pc_enable=0.
- Forwarding priority: reg_writeM=1, rd_addrM=5, reg_writeW=1, rd_addrW=5, rs_addrE=5 -> forward_a=10. Then drop reg_writeM -> forward_a=01. rt_addrE_src=6 -> forward_b=00.
- Reset and saturation:
  - rst_n low mid-countdown (mdu_cnt=3) -> mdu_busy=0 immediately; no mdu_done after release.
  - STALL_CNT_W=3 with 10 stall cycles -> stall_count holds at 7.
  - perf_clear together with a stall -> stall_count=0.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding unit for the 5-stage MIPS core: load-use and MDU interlocks,
// branch/jump bubble, EX forwarding selects and a saturating stall-cycle counter.
module hazard_forward_unit #(
    parameter int REG_ADDR_W       = 5,
    parameter int MDU_LATENCY      = 32,
    parameter int MDU_CNT_W        = 6,
    parameter int STALL_CNT_W      = 32,
    parameter bit ZERO_REG_PROTECT = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_readE,
    input  logic [REG_ADDR_W-1:0]  rt_addrE,
    input  logic [REG_ADDR_W-1:0]  rs_addrD,
    input  logic [REG_ADDR_W-1:0]  rt_addrD,
    input  logic                   rs_usedD,
    input  logic                   rt_usedD,
    input  logic [REG_ADDR_W-1:0]  rs_addrE,
    input  logic [REG_ADDR_W-1:0]  rt_addrE_src,
    input  logic                   reg_writeM,
    input  logic                   reg_writeW,
    input  logic [REG_ADDR_W-1:0]  rd_addrM,
    input  logic [REG_ADDR_W-1:0]  rd_addrW,
    input  logic                   pc_src,
    input  logic                   jumpD,
    input  logic                   mdu_startE,
    input  logic                   mdu_startD,
    input  logic                   hilo_readD,
    input  logic                   perf_clear,
    output logic                   pc_enable,
    output logic                   instr_enable,
    output logic                   control_mux,
    output logic                   flush_ifid,
    output logic [1:0]             forward_a,
    output logic [1:0]             forward_b,
    output logic                   mdu_busy,
    output logic                   mdu_done,
    output logic [STALL_CNT_W-1:0] stall_count
);

    function automatic logic addr_match(input logic [REG_ADDR_W-1:0] a,
                                        input logic [REG_ADDR_W-1:0] b);
        return (a == b) && !(ZERO_REG_PROTECT && (a == '0));
    endfunction

    logic [MDU_CNT_W-1:0]   mdu_cnt_q, mdu_cnt_d;
    logic                   mdu_done_q, mdu_done_d;
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

    logic load_use, mdu_hold, stall;
    logic rs_fwd_m, rs_fwd_w, rt_fwd_m, rt_fwd_w;

    assign load_use = mem_readE &&
                      ((rs_usedD && addr_match(rt_addrE, rs_addrD)) ||
                       (rt_usedD && addr_match(rt_addrE, rt_addrD)));
    assign mdu_busy = (mdu_cnt_q != '0);
    assign mdu_hold = mdu_busy && (hilo_readD || mdu_startD);
    assign stall    = load_use || mdu_hold;

    assign rs_fwd_m = reg_writeM && addr_match(rd_addrM, rs_addrE);
    assign rs_fwd_w = reg_writeW && addr_match(rd_addrW, rs_addrE);
    assign rt_fwd_m = reg_writeM && addr_match(rd_addrM, rt_addrE_src);
    assign rt_fwd_w = reg_writeW && addr_match(rd_addrW, rt_addrE_src);

    always_comb begin
        // NOTE: every output takes a default first, so no branch can leave one held (no latch).
        pc_enable    = 1'b1;
        instr_enable = 1'b1;
        control_mux  = 1'b1;
        flush_ifid   = 1'b0;
        forward_a    = rs_fwd_m ? 2'b10 : (rs_fwd_w ? 2'b01 : 2'b00);
        forward_b    = rt_fwd_m ? 2'b10 : (rt_fwd_w ? 2'b01 : 2'b00);
        if (!rst_n) begin
            pc_enable    = 1'b0;
            instr_enable = 1'b0;
            control_mux  = 1'b0;
            forward_a    = 2'b00;
            forward_b    = 2'b00;
        end else if (stall) begin
            // A stalled branch keeps IF/ID intact and re-resolves next cycle.
            pc_enable    = 1'b0;
            instr_enable = 1'b0;
            control_mux  = 1'b0;
        end else if (pc_src || jumpD) begin
            control_mux  = 1'b0;
            flush_ifid   = 1'b1;
        end
    end

    always_comb begin
        mdu_cnt_d     = mdu_cnt_q;
        // A reload on the final busy cycle cancels the completion pulse.
        mdu_done_d    = (mdu_cnt_q == MDU_CNT_W'(1)) && !mdu_startE;
        stall_count_d = stall_count_q;
        if (mdu_startE) begin
            mdu_cnt_d = MDU_CNT_W'(MDU_LATENCY);
        end else if (mdu_busy) begin
            mdu_cnt_d = mdu_cnt_q - MDU_CNT_W'(1);
        end
        if (perf_clear) begin
            stall_count_d = '0;
        end else if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + STALL_CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdu_cnt_q     <= '0;
            mdu_done_q    <= 1'b0;
            stall_count_q <= '0;
        end else begin
            mdu_cnt_q     <= mdu_cnt_d;
            mdu_done_q    <= mdu_done_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign mdu_done    = mdu_done_q;
    assign stall_count = stall_count_q;

endmodule
